// File: rtl/aplic_msi_forwarder.sv
// APLIC MSI-mode back-end: round-robin scan of pending/enabled sources, one IMSIC write in flight at a time.
// Optional software genmsi injection is compiled in when APLIC_MSI_GENMSI_EN is defined.
module aplic_msi_forwarder #(
    parameter int NR_SRC   = 256,
    parameter int NR_HARTS = 5,
    parameter int XLEN     = 64,
    parameter int HART_W   = (NR_HARTS > 1) ? $clog2(NR_HARTS) : 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_domaincfg_ie,
    input  logic [NR_SRC-1:0]        i_pending,
    input  logic [NR_SRC-1:0]        i_enabled,
    input  logic [NR_SRC*HART_W-1:0] i_target_hart,
    input  logic [NR_SRC*11-1:0]     i_target_eiid,
    input  logic [XLEN-1:0]          i_msi_base,
    output logic [NR_SRC-1:0]        o_clr_ip,
    output logic                     o_msi_valid,
    input  logic                     i_msi_ready,
    output logic [XLEN-1:0]          o_msi_addr,
    output logic [31:0]              o_msi_data,
    input  logic                     i_genmsi_req,
    input  logic [HART_W-1:0]        i_genmsi_hart,
    input  logic [10:0]              i_genmsi_eiid,
    output logic                     o_genmsi_busy
);

    localparam int IDX_W = $clog2(NR_SRC);
    localparam logic [31:0] NR_HARTS_U = NR_HARTS;

    typedef enum logic {SCAN, ISSUE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   src;
    logic [IDX_W-1:0]   idx_next;
    logic [IDX_W-1:0]   src_next;
    logic               clr_pulse;
    logic [HART_W-1:0]  cur_hart;
    logic [10:0]        cur_eiid;
    logic               candidate;

    // Source 0 is invalid, so both the scan pointer and the post-service pointer wrap to 1.
    always_comb begin
        cur_hart  = i_target_hart[idx*HART_W +: HART_W];
        cur_eiid  = i_target_eiid[idx*11 +: 11];
        candidate = i_domaincfg_ie & i_pending[idx] & i_enabled[idx]
                  & (cur_eiid != 11'd0) & (32'(cur_hart) < NR_HARTS_U);
        idx_next  = (idx == IDX_W'(NR_SRC - 1)) ? IDX_W'(1) : idx + IDX_W'(1);
        src_next  = (src == IDX_W'(NR_SRC - 1)) ? IDX_W'(1) : src + IDX_W'(1);
    end

    // The clear pulse lands in the cycle after the handshake edge, decoded from the served index.
    always_comb begin
        o_clr_ip = '0;
        if (clr_pulse)
            o_clr_ip[src] = 1'b1;
    end

`ifdef APLIC_MSI_GENMSI_EN
    logic is_gen;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= SCAN;
            idx           <= IDX_W'(1);
            src           <= '0;
            clr_pulse     <= 1'b0;
            o_msi_valid   <= 1'b0;
            o_msi_addr    <= '0;
            o_msi_data    <= '0;
            o_genmsi_busy <= 1'b0;
            is_gen        <= 1'b0;
        end else begin
            clr_pulse <= 1'b0;
            case (state)
                SCAN: begin
                    // A software request outranks the scan candidate and leaves the scan pointer alone.
                    if (i_genmsi_req) begin
                        o_msi_addr    <= i_msi_base + (XLEN'(i_genmsi_hart) << 12);
                        o_msi_data    <= {21'b0, i_genmsi_eiid};
                        o_msi_valid   <= 1'b1;
                        o_genmsi_busy <= 1'b1;
                        is_gen        <= 1'b1;
                        state         <= ISSUE;
                    end else if (candidate) begin
                        src         <= idx;
                        o_msi_addr  <= i_msi_base + (XLEN'(cur_hart) << 12);
                        o_msi_data  <= {21'b0, cur_eiid};
                        o_msi_valid <= 1'b1;
                        is_gen      <= 1'b0;
                        state       <= ISSUE;
                    end else begin
                        idx <= idx_next;
                    end
                end
                ISSUE: begin
                    if (i_msi_ready) begin
                        o_msi_valid <= 1'b0;
                        state       <= SCAN;
                        if (is_gen) begin
                            o_genmsi_busy <= 1'b0;
                        end else begin
                            clr_pulse <= 1'b1;
                            idx       <= src_next;
                        end
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end
`else
    logic unused_genmsi;
    assign unused_genmsi = ^{i_genmsi_req, i_genmsi_hart, i_genmsi_eiid};
    assign o_genmsi_busy = 1'b0;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= SCAN;
            idx         <= IDX_W'(1);
            src         <= '0;
            clr_pulse   <= 1'b0;
            o_msi_valid <= 1'b0;
            o_msi_addr  <= '0;
            o_msi_data  <= '0;
        end else begin
            clr_pulse <= 1'b0;
            case (state)
                SCAN: begin
                    if (candidate) begin
                        src         <= idx;
                        o_msi_addr  <= i_msi_base + (XLEN'(cur_hart) << 12);
                        o_msi_data  <= {21'b0, cur_eiid};
                        o_msi_valid <= 1'b1;
                        state       <= ISSUE;
                    end else begin
                        idx <= idx_next;
                    end
                end
                // Once raised, valid is held regardless of ie/pending/target changes until accepted.
                ISSUE: begin
                    if (i_msi_ready) begin
                        o_msi_valid <= 1'b0;
                        clr_pulse   <= 1'b1;
                        idx         <= src_next;
                        state       <= SCAN;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_aplic_msi_forwarder.sv
// Scoreboard bench for aplic_msi_forwarder: directed stimulus pushes expected writes, a monitor compares them.
module tb_aplic_msi_forwarder;

    localparam int NR_SRC   = 256;
    localparam int NR_HARTS = 5;
    localparam int XLEN     = 64;
    localparam int HART_W   = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     ie;
    logic [NR_SRC-1:0]        pending;
    logic [NR_SRC-1:0]        enabled;
    logic [NR_SRC*HART_W-1:0] target_hart;
    logic [NR_SRC*11-1:0]     target_eiid;
    logic [XLEN-1:0]          msi_base;
    logic [NR_SRC-1:0]        o_clr_ip;
    logic                     o_msi_valid;
    logic                     i_msi_ready;
    logic [XLEN-1:0]          o_msi_addr;
    logic [31:0]              o_msi_data;
    logic                     genmsi_req;
    logic [HART_W-1:0]        genmsi_hart;
    logic [10:0]              genmsi_eiid;
    logic                     o_genmsi_busy;

    typedef struct {
        logic [XLEN-1:0] addr;
        logic [31:0]     data;
        int              src;
    } exp_t;

    exp_t              sb_q[$];
    int                checks   = 0;
    int                passes   = 0;
    int                hs_count = 0;
    logic [NR_SRC-1:0] clr_exp;

    aplic_msi_forwarder #(
        .NR_SRC   (NR_SRC),
        .NR_HARTS (NR_HARTS),
        .XLEN     (XLEN),
        .HART_W   (HART_W)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_domaincfg_ie (ie),
        .i_pending      (pending),
        .i_enabled      (enabled),
        .i_target_hart  (target_hart),
        .i_target_eiid  (target_eiid),
        .i_msi_base     (msi_base),
        .o_clr_ip       (o_clr_ip),
        .o_msi_valid    (o_msi_valid),
        .i_msi_ready    (i_msi_ready),
        .o_msi_addr     (o_msi_addr),
        .o_msi_data     (o_msi_data),
        .i_genmsi_req   (genmsi_req),
        .i_genmsi_hart  (genmsi_hart),
        .i_genmsi_eiid  (genmsi_eiid),
        .o_genmsi_busy  (o_genmsi_busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion within 30000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_msi(input logic [XLEN-1:0] addr, input logic [31:0] data, input int src);
        exp_t e;
        e.addr = addr;
        e.data = data;
        e.src  = src;
        sb_q.push_back(e);
    endtask

    task automatic set_src(input int s, input int hart, input int eiid);
        target_hart[s*HART_W +: HART_W] = HART_W'(hart);
        target_eiid[s*11 +: 11]         = 11'(eiid);
    endtask

    task automatic wait_hs(input int target, input int budget, input string name);
        int n = 0;
        while (hs_count < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_output(name, 64'(hs_count >= target), 64'd1);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (!o_msi_valid && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check_output(name, 64'(o_msi_valid), 64'd1);
    endtask

    // Monitor: every valid cycle must match the queue head; a handshake pops it and arms the clear-pulse check.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst) begin
                clr_exp = '0;
                continue;
            end
            if (clr_exp != '0 || o_clr_ip != '0) begin
                checks++;
                if (o_clr_ip === clr_exp)
                    passes++;
                else
                    $display("[TB] FAIL clr_ip: got %h, expected %h", o_clr_ip, clr_exp);
            end
            clr_exp = '0;
            if (o_msi_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_msi: got addr 0x%0h data 0x%0h, expected no write",
                             o_msi_addr, o_msi_data);
                end else begin
                    check_output("msi_addr", o_msi_addr, sb_q[0].addr);
                    check_output("msi_data", 64'(o_msi_data), 64'(sb_q[0].data));
                    if (i_msi_ready) begin
                        if (sb_q[0].src >= 0)
                            clr_exp[sb_q[0].src] = 1'b1;
                        void'(sb_q.pop_front());
                        hs_count++;
                    end
                end
            end
        end
    endtask

    task automatic apply_stimulus();
        int start;
        int cnt;

        rst         = 1'b1;
        ie          = 1'b1;
        pending     = '0;
        enabled     = '1;
        target_hart = '0;
        target_eiid = '0;
        msi_base    = 64'h0000_0000_2800_0000;
        i_msi_ready = 1'b1;
        genmsi_req  = 1'b0;
        genmsi_hart = '0;
        genmsi_eiid = '0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_valid", 64'(o_msi_valid), 64'd0);
        check_output("reset_addr", o_msi_addr, 64'd0);
        check_output("reset_data", 64'(o_msi_data), 64'd0);
        check_output("reset_clr", 64'(o_clr_ip != '0), 64'd0);
        check_output("reset_busy", 64'(o_genmsi_busy), 64'd0);
        rst = 1'b0;

        // Round robin from idx 1: 3 first, 200 next although 3 stays pending, then wrap back to 3.
        set_src(3, 1, 17);
        set_src(200, 2, 33);
        pending[3]   = 1'b1;
        pending[200] = 1'b1;
        expect_msi(64'h2800_1000, 32'd17, 3);
        expect_msi(64'h2800_2000, 32'd33, 200);
        expect_msi(64'h2800_1000, 32'd17, 3);
        wait_hs(hs_count + 3, 800, "rr_handshakes");
        pending[3]   = 1'b0;
        pending[200] = 1'b0;

        set_src(5, 3, 42);
        pending[5] = 1'b1;
        expect_msi(64'h2800_3000, 32'd42, 5);
        wait_hs(hs_count + 1, 400, "basic_handshake");
        pending[5] = 1'b0;

        // Stall with ie dropped mid-stall: the write must stay put and still clear on acceptance.
        set_src(20, 2, 100);
        i_msi_ready = 1'b0;
        pending[20] = 1'b1;
        expect_msi(64'h2800_2000, 32'd100, 20);
        wait_valid(400, "stall_valid_rise");
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 2)
                ie = 1'b0;
        end
        check_output("stall_valid_held", 64'(o_msi_valid), 64'd1);
        i_msi_ready = 1'b1;
        wait_hs(hs_count + 1, 5, "stall_handshake");
        ie          = 1'b1;
        pending[20] = 1'b0;

        // Zero EIID, out-of-range hart and disabled source never produce a write.
        set_src(7, 0, 0);
        set_src(8, 6, 5);
        set_src(11, 1, 12);
        enabled[11] = 1'b0;
        pending[7]  = 1'b1;
        pending[8]  = 1'b1;
        pending[11] = 1'b1;
        start = hs_count;
        repeat (300) @(posedge clk);
        #1;
        check_output("skip_no_msi", 64'(hs_count), 64'(start));
        pending[7]  = 1'b0;
        pending[8]  = 1'b0;
        pending[11] = 1'b0;
        enabled[11] = 1'b1;

        set_src(12, 1, 3);
        ie          = 1'b0;
        pending[12] = 1'b1;
        start = hs_count;
        repeat (300) @(posedge clk);
        #1;
        check_output("ie_off_no_msi", 64'(hs_count), 64'(start));
        expect_msi(64'h2800_1000, 32'd3, 12);
        ie = 1'b1;
        wait_hs(hs_count + 1, 400, "ie_on_handshake");
        pending[12] = 1'b0;

        // Highest legal hart, max EIID, and a base that overflows XLEN.
        msi_base = 64'hFFFF_FFFF_FFFF_F000;
        set_src(9, 4, 2047);
        pending[9] = 1'b1;
        expect_msi(64'h0000_0000_0000_3000, 32'h0000_07FF, 9);
        wait_hs(hs_count + 1, 400, "carry_handshake");
        pending[9] = 1'b0;
        msi_base   = 64'h0000_0000_2800_0000;

`ifdef APLIC_MSI_GENMSI_EN
        set_src(4, 0, 6);
        i_msi_ready = 1'b0;
        expect_msi(64'h2800_1000, 32'd9, -1);
        expect_msi(64'h2800_0000, 32'd6, 4);
        genmsi_hart = 3'd1;
        genmsi_eiid = 11'd9;
        genmsi_req  = 1'b1;
        pending[4]  = 1'b1;
        wait_valid(5, "genmsi_valid_rise");
        genmsi_req = 1'b0;
        check_output("genmsi_busy_set", 64'(o_genmsi_busy), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check_output("genmsi_busy_held", 64'(o_genmsi_busy), 64'd1);
        i_msi_ready = 1'b1;
        wait_hs(hs_count + 1, 5, "genmsi_handshake");
        check_output("genmsi_busy_clear", 64'(o_genmsi_busy), 64'd0);
        wait_hs(hs_count + 1, 400, "genmsi_then_src4");
        pending[4] = 1'b0;
`else
        genmsi_hart = 3'd1;
        genmsi_eiid = 11'd9;
        genmsi_req  = 1'b1;
        start = hs_count;
        repeat (20) @(posedge clk);
        #1;
        check_output("genmsi_ignored_busy", 64'(o_genmsi_busy), 64'd0);
        check_output("genmsi_ignored_msi", 64'(hs_count), 64'(start));
        genmsi_req = 1'b0;
`endif

        // Reset while a write is stalled: valid drops at once, no clear, scan restarts at source 1.
        set_src(10, 0, 1);
        i_msi_ready = 1'b0;
        pending[10] = 1'b1;
        expect_msi(64'h2800_0000, 32'd1, 10);
        wait_valid(400, "rst_valid_rise");
        #2;
        rst = 1'b1;
        #1;
        check_output("rst_valid_drop", 64'(o_msi_valid), 64'd0);
        check_output("rst_no_clr", 64'(o_clr_ip != '0), 64'd0);
        sb_q.delete();
        pending[10] = 1'b0;
        set_src(2, 0, 3);
        pending[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst         = 1'b0;
        i_msi_ready = 1'b1;
        expect_msi(64'h2800_0000, 32'd3, 2);
        cnt = 0;
        while (!o_msi_valid && cnt < 300) begin
            @(posedge clk); #1;
            cnt++;
        end
        check_output("rst_restart_latency", 64'(cnt), 64'd2);
        wait_hs(hs_count + 1, 5, "rst_restart_handshake");
        pending[2] = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check_output("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        clr_exp = '0;
        fork
            monitor();
        join_none
        apply_stimulus();
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
